// File: rtl/adc_frame_scheduler_if.sv
// Frame output stream from the ADC frame scheduler to its sink.
// A beat moves on a rising edge with tvalid & tready; once tvalid is high it stays high, with tdata/tlast frozen, until that beat moves.
interface adc_frame_scheduler_if;
    logic [127:0] tdata;
    logic         tvalid;
    logic         tlast;
    logic         tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_frame_scheduler.sv
// Collects one 32-bit sample from every enabled I2S channel using round-robin grants.
// Each complete frame leaves as two 128-bit beats; a timeout zero-fills channels that never report.
module adc_frame_scheduler #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [7:0]                   ch_en,
    input  logic [255:0]                 data,
    input  logic [7:0]                   flag_in,
    output logic [7:0]                   flag_out,
    adc_frame_scheduler_if.master        S_AXIS,
    output logic [15:0]                  miss_cnt,
    output logic                         busy,
    output logic [1:0]                   dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, SEND0 = 2'd2, SEND1 = 2'd3} state_e;

    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    state_e         state_q, state_d;
    logic [7:0]     en_q, en_d;
    logic [7:0]     got_q, got_d;
    logic [255:0]   slot_q, slot_d;
    logic [2:0]     rr_q, rr_d;
    logic [15:0]    timer_q, timer_d;
    logic [7:0]     flag_out_q, flag_out_d;
    logic [127:0]   tdata_q, tdata_d;
    logic           tvalid_q, tvalid_d;
    logic           tlast_q, tlast_d;
    logic [15:0]    miss_q, miss_d;
    logic           busy_q, busy_d;

    logic [7:0]     elig;
    logic           grant_found;
    logic [2:0]     grant_idx;
    logic [2:0]     cand;
    logic [16:0]    miss_sum;
    logic           latch;

    assign elig = flag_in & en_q & ~got_q;

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        got_d       = got_q;
        slot_d      = slot_q;
        rr_d        = rr_q;
        timer_d     = timer_q;
        flag_out_d  = 8'h00;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        miss_d      = miss_q;
        latch       = 1'b0;
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        cand        = 3'd0;
        miss_sum    = {1'b0, miss_q} + 17'($countones(en_q & ~got_q));

        // Scan starts at the round-robin pointer and wraps modulo 8.
        for (int j = 0; j < 8; j++) begin
            cand = rr_q + 3'(j);
            if (!grant_found && elig[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (start && (ch_en != 8'h00)) begin
                    latch   = 1'b1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (!start) begin
                    state_d = IDLE;
                    got_d   = 8'h00;
                end else if ((got_q != 8'h00) && (timer_q == TIMEOUT_M1)) begin
                    miss_d   = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
                    state_d  = SEND0;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    tdata_d  = slot_q[127:0];
                end else begin
                    if (got_q != 8'h00) begin
                        timer_d = timer_q + 16'd1;
                    end
                    if (grant_found) begin
                        slot_d[{grant_idx, 5'd0} +: 32] = data[{grant_idx, 5'd0} +: 32];
                        got_d[grant_idx]      = 1'b1;
                        flag_out_d[grant_idx] = 1'b1;
                        rr_d                  = grant_idx + 3'd1;
                    end
                    // The beat is loaded from slot_d so the final capture lands in it without a wait cycle.
                    if (got_d == en_q) begin
                        state_d  = SEND0;
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b0;
                        tdata_d  = slot_d[127:0];
                    end
                end
            end
            SEND0: begin
                if (S_AXIS.tready) begin
                    state_d = SEND1;
                    tdata_d = slot_q[255:128];
                    tlast_d = 1'b1;
                end
            end
            SEND1: begin
                if (S_AXIS.tready) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    tdata_d  = 128'h0;
                    if (start && (ch_en != 8'h00)) begin
                        latch   = 1'b1;
                        state_d = COLLECT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (latch) begin
            en_d    = ch_en;
            got_d   = 8'h00;
            slot_d  = 256'h0;
            timer_d = 16'h0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            en_q       <= 8'h00;
            got_q      <= 8'h00;
            slot_q     <= 256'h0;
            rr_q       <= 3'd0;
            timer_q    <= 16'h0;
            flag_out_q <= 8'h00;
            tdata_q    <= 128'h0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            miss_q     <= 16'h0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            got_q      <= got_d;
            slot_q     <= slot_d;
            rr_q       <= rr_d;
            timer_q    <= timer_d;
            flag_out_q <= flag_out_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            miss_q     <= miss_d;
            busy_q     <= busy_d;
        end
    end

    assign flag_out      = flag_out_q;
    assign S_AXIS.tdata  = tdata_q;
    assign S_AXIS.tvalid = tvalid_q;
    assign S_AXIS.tlast  = tlast_q;
    assign miss_cnt      = miss_q;
    assign busy          = busy_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Directed bench for adc_frame_scheduler: expected acks and beats go into queues,
// and a forked monitor pops and compares them whenever the DUT presents an ack or a beat.
module tb_adc_frame_scheduler;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [7:0]     ch_en;
    logic [255:0]   data;
    logic [7:0]     flag_in;
    logic [7:0]     flag_out;
    logic [15:0]    miss_cnt;
    logic           busy;
    logic [1:0]     dbg_state;
    logic [7:0]     rearm;
    int             cyc = 0;
    int             total = 0;
    int             bad = 0;

    logic [128:0]   exp_q[$];
    logic [7:0]     exp_ack_q[$];
    int             ack_cyc_q[$];
    int             beat_cyc_q[$];

    adc_frame_scheduler_if axis ();

    adc_frame_scheduler #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ch_en     (ch_en),
        .data      (data),
        .flag_in   (flag_in),
        .flag_out  (flag_out),
        .S_AXIS    (axis),
        .miss_cnt  (miss_cnt),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Channels drop their flag once they see their ack, unless marked in rearm.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            flag_in = flag_in & ~(flag_out & ~rearm);
        end
    endtask

    function automatic logic [255:0] frame_of(input logic [7:0] m);
        logic [255:0] r;
        r = 256'h0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) r[32*i +: 32] = 32'hA000_0000 + 32'(i);
        end
        return r;
    endfunction

    task automatic push_frame(input logic [7:0] m);
        logic [255:0] f;
        f = frame_of(m);
        exp_q.push_back({1'b0, f[127:0]});
        exp_q.push_back({1'b1, f[255:128]});
    endtask

    task automatic push_ack(input int ch);
        exp_ack_q.push_back(8'(1 << ch));
    endtask

    task automatic monitor();
        logic         stall_prev;
        logic [129:0] stall_val;
        logic [128:0] e;
        stall_prev = 1'b0;
        stall_val  = '0;
        forever begin
            @(negedge clk);
            if (flag_out != 8'h00) begin
                ack_cyc_q.push_back(cyc);
                if (exp_ack_q.size() == 0) check("ack_unexpected", flag_out, 0);
                else begin
                    e[7:0] = exp_ack_q.pop_front();
                    check("ack_order", flag_out, e[7:0]);
                end
            end
            if (stall_prev) check("axis_hold", {axis.tvalid, axis.tlast, axis.tdata}, stall_val);
            if (axis.tvalid && axis.tready) begin
                beat_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) check("beat_unexpected", {axis.tlast, axis.tdata}, 0);
                else begin
                    e = exp_q.pop_front();
                    check("beat", {axis.tlast, axis.tdata}, e);
                end
            end
            stall_prev = axis.tvalid && !axis.tready;
            stall_val  = {1'b1, axis.tlast, axis.tdata};
        end
    endtask

    task automatic run_frame(input logic [7:0] en, input logic [7:0] fl);
        int n;
        ch_en = en;
        flag_in = fl;
        start = 1'b1;
        n = 0;
        while (exp_q.size() > 1 && n < 200) begin tick(1); n++; end
        start = 1'b0;
        while (exp_q.size() > 0 && n < 200) begin tick(1); n++; end
        check("frame_done", exp_q.size(), 0);
        tick(2);
    endtask

    initial begin
        int n;
        int na;
        logic [255:0] f;
        logic [127:0] hold;

        rst = 1'b0;
        start = 1'b0;
        ch_en = 8'h00;
        flag_in = 8'h00;
        rearm = 8'h00;
        axis.tready = 1'b1;
        for (int i = 0; i < 8; i++) data[32*i +: 32] = 32'hA000_0000 + 32'(i);
        fork monitor(); join_none

        // Reset state
        tick(3);
        check("rst_flag_out", flag_out, 0);
        check("rst_tvalid", axis.tvalid, 0);
        check("rst_tlast", axis.tlast, 0);
        check("rst_tdata", axis.tdata, 0);
        check("rst_miss", miss_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b1;
        tick(2);

        // All channels, two back-to-back frames
        ack_cyc_q.delete();
        beat_cyc_q.delete();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) push_ack(i);
            exp_q.push_back({1'b0, 128'hA0000003_A0000002_A0000001_A0000000});
            exp_q.push_back({1'b1, 128'hA0000007_A0000006_A0000005_A0000004});
        end
        rearm = 8'hFF;
        flag_in = 8'hFF;
        ch_en = 8'hFF;
        start = 1'b1;
        n = 0;
        while (exp_q.size() > 1 && n < 100) begin tick(1); n++; end
        start = 1'b0;
        rearm = 8'h00;
        flag_in = 8'h00;
        while (exp_q.size() > 0 && n < 100) begin tick(1); n++; end
        check("t2_done", exp_q.size(), 0);
        tick(2);
        check("t2_ack_count", ack_cyc_q.size(), 16);
        check("t2_beat_count", beat_cyc_q.size(), 4);
        if (ack_cyc_q.size() == 16 && beat_cyc_q.size() == 4) begin
            check("t2_ack_span", ack_cyc_q[7] - ack_cyc_q[0], 7);
            check("t2_beat0_with_last_ack", beat_cyc_q[0] - ack_cyc_q[7], 0);
            check("t2_beat1_next", beat_cyc_q[1] - ack_cyc_q[7], 1);
            check("t2_period", ack_cyc_q[8] - ack_cyc_q[0], 10);
            check("t2_f2_beat0", beat_cyc_q[2] - ack_cyc_q[15], 0);
        end
        check("t2_miss", miss_cnt, 0);
        check("t2_idle", busy, 0);

        // Round robin: ch2 alone leaves rr=3, then ch5 wins over ch2
        push_ack(2);
        push_frame(8'h04);
        run_frame(8'h04, 8'h04);
        push_ack(5); push_ack(2);
        push_frame(8'h24);
        run_frame(8'h24, 8'h24);
        push_ack(5); push_ack(1); push_ack(2);
        push_frame(8'h26);
        run_frame(8'h26, 8'h26);

        // Backpressure in SEND0 (rr=3)
        for (int i = 0; i < 8; i++) push_ack((3 + i) % 8);
        push_frame(8'hFF);
        axis.tready = 1'b0;
        ch_en = 8'hFF;
        flag_in = 8'hFF;
        start = 1'b1;
        n = 0;
        while (!axis.tvalid && n < 50) begin tick(1); n++; end
        check("bp_valid", axis.tvalid, 1);
        hold = axis.tdata;
        repeat (5) begin
            tick(1);
            check("bp_hold", {axis.tvalid, axis.tlast, axis.tdata}, {2'b10, hold});
            check("bp_noack", flag_out, 0);
            check("bp_busy", busy, 1);
        end
        axis.tready = 1'b1;
        start = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin tick(1); n++; end
        check("bp_done", exp_q.size(), 0);
        tick(2);

        // Timeout: ch6 never reports
        for (int k = 0; k < 2; k++) begin
            ack_cyc_q.delete();
            beat_cyc_q.delete();
            push_ack(3); push_ack(4); push_ack(5); push_ack(7);
            push_ack(0); push_ack(1); push_ack(2);
            push_frame(8'hBF);
            run_frame(8'hFF, 8'hBF);
            check("to_miss", miss_cnt, 16'(k + 1));
            if (ack_cyc_q.size() == 7 && beat_cyc_q.size() == 2)
                check("to_latency", beat_cyc_q[0] - ack_cyc_q[0], 16);
            else
                check("to_counts", {ack_cyc_q.size(), beat_cyc_q.size()}, {32'd7, 32'd2});
        end

        // Partial enable, then empty enable
        push_ack(3); push_ack(0); push_ack(1); push_ack(2);
        push_frame(8'h0F);
        run_frame(8'h0F, 8'h0F);
        ch_en = 8'h00;
        flag_in = 8'hFF;
        start = 1'b1;
        tick(5);
        check("en0_busy", busy, 0);
        check("en0_state", dbg_state, 0);
        check("en0_tvalid", axis.tvalid, 0);
        start = 1'b0;
        flag_in = 8'h00;
        tick(1);

        // Abort after three grants; the pending third ack is still driven
        push_ack(3); push_ack(4); push_ack(5);
        ch_en = 8'hFF;
        flag_in = 8'hFF;
        start = 1'b1;
        n = 0;
        na = 0;
        while (na < 3 && n < 50) begin
            tick(1);
            n++;
            if (flag_out != 8'h00) na++;
        end
        start = 1'b0;
        tick(10);
        check("abort_busy", busy, 0);
        check("abort_state", dbg_state, 0);
        check("abort_acks", exp_ack_q.size(), 0);

        // Reset in the middle of SEND1 (rr=6)
        for (int i = 0; i < 8; i++) push_ack((6 + i) % 8);
        f = frame_of(8'hFF);
        exp_q.push_back({1'b0, f[127:0]});
        ch_en = 8'hFF;
        flag_in = 8'hFF;
        start = 1'b1;
        n = 0;
        while (!axis.tlast && n < 50) begin tick(1); n++; end
        check("rst_mid_send1", dbg_state, 3);
        rst = 1'b0;
        #1;
        check("rstm_tvalid", axis.tvalid, 0);
        check("rstm_tlast", axis.tlast, 0);
        check("rstm_tdata", axis.tdata, 0);
        check("rstm_flag_out", flag_out, 0);
        check("rstm_busy", busy, 0);
        check("rstm_miss", miss_cnt, 0);
        start = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);

        check("end_beats_left", exp_q.size(), 0);
        check("end_acks_left", exp_ack_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_frame_scheduler.md
# adc_frame_scheduler

Frame-level scheduler between the eight I2S ADC channel receivers and the AXI-Stream sink. Collects one 32-bit sample from every enabled channel through the per-channel flag handshake, granting channels round-robin with at most one capture per cycle. Emits each complete frame as two 128-bit beats with `tlast` on the second. A timeout zero-fills missing channels so one dead microphone cannot stall the stream.

## Interface
- `TIMEOUT`, default 255: cycles allowed between the first capture of a frame and forced completion; valid range 1..65535.
- `clk`  in  1  sampling clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level enable; low means the scheduler idles.
- `ch_en`  in  8  channel enable mask; latched on IDLE->COLLECT.
- `data`  in  256  channel i sample on bits [32i+31:32i].
- `flag_in`  in  8  channel i has a sample ready; held high until acknowledged.
- `flag_out`  out  8  one-cycle acknowledge pulse to channel i.
- `S_AXIS_tdata`  out  128  frame beat.
- `S_AXIS_tvalid`  out  1  beat valid.
- `S_AXIS_tlast`  out  1  high on the second beat of a frame.
- `S_AXIS_tready`  in  1  sink ready.
- `miss_cnt`  out  16  saturating count of channel slots zero-filled by timeout.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, COLLECT, SEND0, SEND1.
- Internal state: `en_q` (8), `got` (8), `slot[0..7]` (32 each), round-robin pointer `rr` (3), timer (16).
- IDLE -> COLLECT when `start`=1 and `ch_en`!=0.
  - On the transition: `en_q`<=`ch_en`, `got`<=0, all slots <=0, timer <=0.
  - When `ch_en`=0, stay in IDLE.
- COLLECT, each cycle:
  - Eligible channel: `flag_in[i] & en_q[i] & ~got[i]`.
  - Grant the first eligible channel scanning `rr`, `rr+1`, … modulo 8.
  - On a grant: `slot[i]`<=`data[i]`, `got[i]`<=1, `flag_out[i]`=1 for exactly the next cycle, `rr`<=i+1 modulo 8.
  - At most one grant per cycle.
- COLLECT exits:
  - When `got`==`en_q` (after the update), go to SEND0.
  - Timer counts each cycle once `got`!=0. When timer reaches `TIMEOUT`-1 with `got`!=`en_q`:
    - `miss_cnt` += popcount(`en_q & ~got`), saturating at 16'hFFFF.
    - Missing slots stay 0.
    - Go to SEND0. No grant is issued in that cycle.
  - `start`=0 in COLLECT aborts the frame: go to IDLE, discard captures, issue no further acks. An ack already scheduled for the next cycle is still driven.
- SEND0: `tdata`={slot3,slot2,slot1,slot0}, `tvalid`=1, `tlast`=0. On `tready`, go to SEND1.
- SEND1: `tdata`={slot7,slot6,slot5,slot4}, `tvalid`=1, `tlast`=1. On `tready`:
  - Go to COLLECT if `start`=1 and `ch_en`!=0, re-latching as on IDLE->COLLECT.
  - Otherwise go to IDLE.
- `start` falling during SEND0/SEND1 does not truncate the frame.
- Disabled channels never receive `flag_out`; their slots transmit 0.
- `flag_in` on any channel during SEND0/SEND1/IDLE is ignored. Channels hold their flag until COLLECT.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; `flag_out`, `tdata`, `tvalid`, `tlast`, `miss_cnt`, `busy`, `rr`, `got`, timer all 0.
- All outputs are registered.
- Grant latency: `flag_in[i]` high at edge k -> `flag_out[i]` high in cycle k..k+1 only.
- Completion latency: last grant at edge k -> `tvalid`=1 in the same cycle as the last `flag_out`.
- AXIS rules:
  - `tdata`/`tlast` stay stable while `tvalid`=1 and `tready`=0.
  - `tvalid` never drops without a handshake.
  - A beat transfers on an edge with `tvalid & tready`.
- Minimum frame period with all 8 channels ready and `tready`=1: 8 COLLECT cycles + 2 SEND cycles = 10 cycles.
- `busy` = (state != IDLE), registered with state.

## Test plan
- All channels ready, `ch_en`=8'hFF, `data[i]`=32'hA0000000+i, `tready`=1 -> `flag_out` pulses ch0..ch7 on consecutive cycles; beat0=`{A3,A2,A1,A0}` `tlast`=0, beat1=`{A7..A4}` `tlast`=1; frame period 10 cycles.
- Round-robin fairness: ch2 and ch5 ready after `rr`=3 -> ch5 granted before ch2; across two frames the grant order rotates.
- Backpressure: `tready`=0 for 5 cycles during SEND0 -> `tdata`/`tvalid` constant; no ack issued; then beats transfer in order.
- Timeout: `TIMEOUT`=16, ch6 never raises `flag_in` -> frame sent 16 cycles after first grant, slot6=0, `miss_cnt`=1; a second identical frame gives `miss_cnt`=2.
- `ch_en`=8'h0F -> only ch0..3 acked; beat1=128'h0; `ch_en`=0 with `start`=1 -> stays IDLE, `busy`=0.
- Abort/reset: `start`=0 after 3 grants -> IDLE, no AXIS beat; `rst` low mid-SEND1 -> all outputs 0 immediately.
